// File: rtl/boot_bus_pkg.sv
// Shared types and constants for the boot bus sequencer: FSM states, bus owners
// and the value the shared bus rests at when nobody owns it.
package boot_bus_pkg;

  typedef enum logic [2:0] {
    ST_START,
    ST_COPY,
    ST_DRAIN,
    ST_CPU_RST,
    ST_RUN,
    ST_QUIESCE,
    ST_ERROR
  } boot_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_COPIER,
    OWNER_CPU
  } bus_owner_t;

  localparam logic [15:0] IDLE_ADDRESS = 16'hFFFF;
  localparam logic        IDLE_STROBE  = 1'b1;

  // The copier must see its reset on at least one edge before being released.
  localparam int START_CYCLES = 2;

endpackage

// File: rtl/boot_bus_mux.sv
// Combinational shared-bus mux driven by the registered owner select, so the
// selected master's signals reach the memories with zero added latency.
module boot_bus_mux
  import boot_bus_pkg::*;
(
  input  bus_owner_t  owner,
  input  logic [15:0] copier_address,
  input  logic        copier_ram_we_n,
  input  logic        copier_ram_cs_n,
  input  logic        copier_eeprom_oe_n,
  input  logic        copier_eeprom_cs_n,
  input  logic [15:0] cpu_address,
  input  logic        cpu_ram_we_n,
  input  logic        cpu_ram_cs_n,
  output logic [15:0] mem_address,
  output logic        ram_we_n,
  output logic        ram_cs_n,
  output logic        eeprom_oe_n,
  output logic        eeprom_cs_n
);

  always_comb begin
    mem_address = IDLE_ADDRESS;
    ram_we_n    = IDLE_STROBE;
    ram_cs_n    = IDLE_STROBE;
    eeprom_oe_n = IDLE_STROBE;
    eeprom_cs_n = IDLE_STROBE;
    case (owner)
      OWNER_COPIER: begin
        mem_address = copier_address;
        ram_we_n    = copier_ram_we_n;
        ram_cs_n    = copier_ram_cs_n;
        eeprom_oe_n = copier_eeprom_oe_n;
        eeprom_cs_n = copier_eeprom_cs_n;
      end
      // The CPU never reaches the EEPROM; its strobes stay parked high.
      OWNER_CPU: begin
        mem_address = cpu_address;
        ram_we_n    = cpu_ram_we_n;
        ram_cs_n    = cpu_ram_cs_n;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/boot_bus_sequencer.sv
// Arbitrates the shared RAM/EEPROM bus between the boot copier and the CPU,
// sequencing copy, bus turnaround, CPU reset release, timeout and reboot.
module boot_bus_sequencer
  import boot_bus_pkg::*;
#(
  parameter int COPY_TIMEOUT_CYCLES   = 40000,
  parameter int HANDOFF_CYCLES        = 4,
  parameter int CPU_RESET_HOLD_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reboot_req,
  output logic        copier_reset_n,
  input  logic [15:0] copier_address,
  input  logic        copier_ram_we_n,
  input  logic        copier_ram_cs_n,
  input  logic        copier_eeprom_oe_n,
  input  logic        copier_eeprom_cs_n,
  input  logic        copier_done,
  input  logic [15:0] cpu_address,
  input  logic        cpu_ram_we_n,
  input  logic        cpu_ram_cs_n,
  output logic [15:0] mem_address,
  output logic        ram_we_n,
  output logic        ram_cs_n,
  output logic        eeprom_oe_n,
  output logic        eeprom_cs_n,
  output logic        cpu_reset_n,
  output logic        cpu_bus_enable,
  output logic        booted,
  output logic        boot_error
);

  localparam int CW = $clog2(COPY_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_MAX    = '1;
  localparam logic [CW-1:0] START_LAST   = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(COPY_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HANDOFF_LAST = CW'(HANDOFF_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(CPU_RESET_HOLD_CYCLES - 1);

  boot_state_t   state;
  bus_owner_t    owner;
  logic [CW-1:0] counter;
  logic          reboot_q;
  logic          reboot_edge;

  assign reboot_edge = reboot_req & ~reboot_q;

  // One counter times every state; it restarts on each entry and saturates
  // while parked in RUN or ERROR.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_START;
      owner          <= OWNER_NONE;
      counter        <= '0;
      reboot_q       <= 1'b0;
      copier_reset_n <= 1'b0;
      cpu_reset_n    <= 1'b0;
      cpu_bus_enable <= 1'b0;
      booted         <= 1'b0;
      boot_error     <= 1'b0;
    end else begin
      reboot_q <= reboot_req;
      counter  <= (counter == COUNT_MAX) ? counter : counter + 1'b1;
      case (state)
        ST_START: begin
          if (counter == START_LAST) begin
            state          <= ST_COPY;
            owner          <= OWNER_COPIER;
            counter        <= '0;
            copier_reset_n <= 1'b1;
          end
        end
        ST_COPY: begin
          if (copier_done) begin
            state          <= ST_DRAIN;
            owner          <= OWNER_NONE;
            counter        <= '0;
            copier_reset_n <= 1'b0;
          end else if (counter == TIMEOUT_LAST) begin
            state          <= ST_ERROR;
            owner          <= OWNER_NONE;
            counter        <= '0;
            copier_reset_n <= 1'b0;
            cpu_reset_n    <= 1'b0;
            boot_error     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (counter == HANDOFF_LAST) begin
            state          <= ST_CPU_RST;
            owner          <= OWNER_CPU;
            counter        <= '0;
            cpu_bus_enable <= 1'b1;
          end
        end
        ST_CPU_RST: begin
          if (counter == HOLD_LAST) begin
            state       <= ST_RUN;
            counter     <= '0;
            cpu_reset_n <= 1'b1;
            booted      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (reboot_edge) begin
            state          <= ST_QUIESCE;
            owner          <= OWNER_NONE;
            counter        <= '0;
            cpu_reset_n    <= 1'b0;
            cpu_bus_enable <= 1'b0;
            booted         <= 1'b0;
          end
        end
        ST_QUIESCE: begin
          if (counter == HANDOFF_LAST) begin
            state   <= ST_START;
            counter <= '0;
          end
        end
        ST_ERROR: begin
          if (reboot_edge) begin
            state      <= ST_QUIESCE;
            counter    <= '0;
            boot_error <= 1'b0;
          end
        end
        default: begin
          state   <= ST_START;
          owner   <= OWNER_NONE;
          counter <= '0;
        end
      endcase
    end
  end

  boot_bus_mux u_mux (
    .owner              (owner),
    .copier_address     (copier_address),
    .copier_ram_we_n    (copier_ram_we_n),
    .copier_ram_cs_n    (copier_ram_cs_n),
    .copier_eeprom_oe_n (copier_eeprom_oe_n),
    .copier_eeprom_cs_n (copier_eeprom_cs_n),
    .cpu_address        (cpu_address),
    .cpu_ram_we_n       (cpu_ram_we_n),
    .cpu_ram_cs_n       (cpu_ram_cs_n),
    .mem_address        (mem_address),
    .ram_we_n           (ram_we_n),
    .ram_cs_n           (ram_cs_n),
    .eeprom_oe_n        (eeprom_oe_n),
    .eeprom_cs_n        (eeprom_cs_n)
  );

endmodule

// File: tb/tb_boot_bus_sequencer.sv
// Scoreboard bench: stimulus queues the expected sequence of output phases and
// their lengths; a negedge monitor splits the outputs into phases and checks them.
module tb_boot_bus_sequencer;

  localparam int TIMEOUT   = 600;
  localparam int HANDOFF   = 4;
  localparam int HOLD      = 8;
  localparam int START_LEN = 2;
  localparam int COPY_LEN  = 512;
  localparam int RUN_HOLD  = 20;
  localparam int MID_CUT   = 100;

  logic        clock;
  logic        reset;
  logic        reboot_req;
  logic        copier_reset_n;
  logic [15:0] copier_address;
  logic        copier_ram_we_n;
  logic        copier_ram_cs_n;
  logic        copier_eeprom_oe_n;
  logic        copier_eeprom_cs_n;
  logic        copier_done;
  logic [15:0] cpu_address;
  logic        cpu_ram_we_n;
  logic        cpu_ram_cs_n;
  logic [15:0] mem_address;
  logic        ram_we_n;
  logic        ram_cs_n;
  logic        eeprom_oe_n;
  logic        eeprom_cs_n;
  logic        cpu_reset_n;
  logic        cpu_bus_enable;
  logic        booted;
  logic        boot_error;

  boot_bus_sequencer #(
    .COPY_TIMEOUT_CYCLES   (TIMEOUT),
    .HANDOFF_CYCLES        (HANDOFF),
    .CPU_RESET_HOLD_CYCLES (HOLD)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .reboot_req         (reboot_req),
    .copier_reset_n     (copier_reset_n),
    .copier_address     (copier_address),
    .copier_ram_we_n    (copier_ram_we_n),
    .copier_ram_cs_n    (copier_ram_cs_n),
    .copier_eeprom_oe_n (copier_eeprom_oe_n),
    .copier_eeprom_cs_n (copier_eeprom_cs_n),
    .copier_done        (copier_done),
    .cpu_address        (cpu_address),
    .cpu_ram_we_n       (cpu_ram_we_n),
    .cpu_ram_cs_n       (cpu_ram_cs_n),
    .mem_address        (mem_address),
    .ram_we_n           (ram_we_n),
    .ram_cs_n           (ram_cs_n),
    .eeprom_oe_n        (eeprom_oe_n),
    .eeprom_cs_n        (eeprom_cs_n),
    .cpu_reset_n        (cpu_reset_n),
    .cpu_bus_enable     (cpu_bus_enable),
    .booted             (booted),
    .boot_error         (boot_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Copier model: raises done in its COPY_LEN-th cycle out of reset unless stalled.
  logic [15:0] copy_count;
  logic        copier_stall;

  always @(posedge clock) begin
    if (reset || !copier_reset_n) begin
      copy_count  <= 16'd0;
      copier_done <= 1'b0;
    end else begin
      copy_count  <= copy_count + 16'd1;
      copier_done <= !copier_stall && (copy_count + 16'd1 >= 16'(COPY_LEN - 1));
    end
  end

  assign copier_address     = copy_count;
  assign copier_ram_we_n    = copy_count[0];
  assign copier_ram_cs_n    = 1'b0;
  assign copier_eeprom_oe_n = 1'b0;
  assign copier_eeprom_cs_n = 1'b0;

  // Phase snapshot; bus: 0 idle, 1 copier routed, 2 CPU routed, 3 anything else.
  typedef struct packed {
    logic       crn;
    logic       cprn;
    logic       en;
    logic       bt;
    logic       err;
    logic [1:0] bus;
  } snap_t;

  typedef struct {
    snap_t s;
    int    len;
  } phase_t;

  localparam snap_t S_IDLE   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
  localparam snap_t S_COPY   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
  localparam snap_t S_CPURST = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
  localparam snap_t S_RUN    = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
  localparam snap_t S_ERR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};

  phase_t exp_q[$];
  int     tests_run;
  int     tests_failed;
  int     phase_num;

  function automatic logic [1:0] bus_code();
    if (mem_address == 16'hFFFF && ram_we_n && ram_cs_n && eeprom_oe_n && eeprom_cs_n)
      return 2'd0;
    if (mem_address == copier_address && ram_we_n == copier_ram_we_n &&
        ram_cs_n == copier_ram_cs_n && eeprom_oe_n == copier_eeprom_oe_n &&
        eeprom_cs_n == copier_eeprom_cs_n)
      return 2'd1;
    if (mem_address == cpu_address && ram_we_n == cpu_ram_we_n &&
        ram_cs_n == cpu_ram_cs_n && eeprom_oe_n && eeprom_cs_n)
      return 2'd2;
    return 2'd3;
  endfunction

  task automatic expect_phase(input snap_t st, input int n);
    phase_t p;
    p.s   = st;
    p.len = n;
    exp_q.push_back(p);
  endtask

  task automatic check_phase(input snap_t got, input int n);
    phase_t p;
    tests_run++;
    phase_num++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL phase%0d unexpected: got state=%b len=%0d, nothing expected",
               phase_num, got, n);
    end else begin
      p = exp_q.pop_front();
      if (got != p.s || n != p.len) begin
        tests_failed++;
        $display("[TB] FAIL phase%0d: got state=%b len=%0d, expected state=%b len=%0d",
                 phase_num, got, n, p.s, p.len);
      end
    end
  endtask

  // Monitor: a phase ends when the snapshot changes or reset cuts it short.
  snap_t cur_snap;
  snap_t now_snap;
  int    run_len;

  always @(negedge clock) begin
    if (reset) begin
      if (run_len > 0) check_phase(cur_snap, run_len);
      run_len = 0;
    end else begin
      now_snap = {copier_reset_n, cpu_reset_n, cpu_bus_enable, booted, boot_error, bus_code()};
      if (run_len == 0) begin
        cur_snap = now_snap;
        run_len  = 1;
      end else if (now_snap == cur_snap) begin
        run_len++;
      end else begin
        check_phase(cur_snap, run_len);
        cur_snap = now_snap;
        run_len  = 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_copier_reset_n"}, {15'd0, copier_reset_n}, 16'd0);
    check_output({tag, "_cpu_reset_n"}, {15'd0, cpu_reset_n}, 16'd0);
    check_output({tag, "_cpu_bus_enable"}, {15'd0, cpu_bus_enable}, 16'd0);
    check_output({tag, "_booted"}, {15'd0, booted}, 16'd0);
    check_output({tag, "_boot_error"}, {15'd0, boot_error}, 16'd0);
    check_output({tag, "_mem_address"}, mem_address, 16'hFFFF);
    check_output({tag, "_strobes"}, {12'd0, ram_we_n, ram_cs_n, eeprom_oe_n, eeprom_cs_n},
                 16'h000F);
  endtask

  // sel: 0 booted, 1 boot_error, 2 copier_reset_n released.
  task automatic wait_until(input string what, input int sel, input int budget);
    int  n;
    logic hit;
    n = 0;
    forever begin
      @(negedge clock);
      case (sel)
        0:       hit = booted;
        1:       hit = boot_error;
        default: hit = copier_reset_n;
      endcase
      if (hit) return;
      n++;
      if (n >= budget) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL wait_%s: not seen within %0d cycles", what, budget);
        return;
      end
    end
  endtask

  task automatic apply_release_for_boot();
    expect_phase(S_IDLE, START_LEN);
    expect_phase(S_COPY, COPY_LEN);
    expect_phase(S_IDLE, HANDOFF);
    expect_phase(S_CPURST, HOLD);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    phase_num    = 0;
    run_len      = 0;
    reset        = 1'b1;
    reboot_req   = 1'b0;
    copier_stall = 1'b0;
    cpu_address  = 16'h1234;
    cpu_ram_we_n = 1'b0;
    cpu_ram_cs_n = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("por");

    // Normal boot, then the CPU-owned mux in RUN.
    apply_release_for_boot();
    wait_until("booted1", 0, COPY_LEN + 200);
    check_output("run_mem_address", mem_address, 16'h1234);
    check_output("run_strobes", {12'd0, ram_we_n, ram_cs_n, eeprom_oe_n, eeprom_cs_n},
                 16'h0003);
    @(posedge clock);
    #1 cpu_address = 16'hABCD;
    cpu_ram_we_n = 1'b1;
    @(negedge clock);
    check_output("run_mux_same_cycle_addr", mem_address, 16'hABCD);
    check_output("run_mux_same_cycle_we", {15'd0, ram_we_n}, 16'd1);
    repeat (RUN_HOLD - 1) @(posedge clock);

    // Reboot held high for ~100 cycles, with an ignored pulse in the new copy.
    expect_phase(S_RUN, RUN_HOLD + 1);
    expect_phase(S_IDLE, HANDOFF + START_LEN);
    expect_phase(S_COPY, COPY_LEN);
    expect_phase(S_IDLE, HANDOFF);
    expect_phase(S_CPURST, HOLD);
    #1 reboot_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_output("reboot_cpu_reset_n", {15'd0, cpu_reset_n}, 16'd0);
    check_output("reboot_booted", {15'd0, booted}, 16'd0);
    repeat (99) @(posedge clock);
    #1 reboot_req = 1'b0;
    repeat (50) @(posedge clock);
    #1 reboot_req = 1'b1;
    @(posedge clock);
    #1 reboot_req = 1'b0;
    wait_until("booted2", 0, COPY_LEN + 200);
    repeat (RUN_HOLD) @(posedge clock);
    expect_phase(S_RUN, RUN_HOLD);
    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_reset_values("run_reset");

    // Copy timeout, then reboot out of ERROR and reset mid-copy.
    copier_stall = 1'b1;
    expect_phase(S_IDLE, START_LEN);
    expect_phase(S_COPY, TIMEOUT);
    @(posedge clock);
    #1 reset = 1'b0;
    wait_until("boot_error", 1, TIMEOUT + 100);
    check_output("err_cpu_reset_n", {15'd0, cpu_reset_n}, 16'd0);
    check_output("err_copier_reset_n", {15'd0, copier_reset_n}, 16'd0);
    check_output("err_strobes", {12'd0, ram_we_n, ram_cs_n, eeprom_oe_n, eeprom_cs_n},
                 16'h000F);
    copier_stall = 1'b0;
    repeat (10) @(posedge clock);
    expect_phase(S_ERR, 11);
    expect_phase(S_IDLE, HANDOFF + START_LEN);
    #1 reboot_req = 1'b1;
    wait_until("copy_restart", 2, 50);
    @(posedge clock);
    #1 reboot_req = 1'b0;
    repeat (MID_CUT - 1) @(posedge clock);
    expect_phase(S_COPY, MID_CUT);
    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_reset_values("mid_copy_reset");
    repeat (2) @(posedge clock);

    // Restart after the mid-copy reset runs a full boot again.
    apply_release_for_boot();
    wait_until("booted3", 0, COPY_LEN + 200);
    repeat (RUN_HOLD) @(posedge clock);
    expect_phase(S_RUN, RUN_HOLD);
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check_output("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
